// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and defaults for the PWM comparator slice.
//   pwm_state_t : controller state (IDLE, ARM, RUN)
//   CNT_W_DEF   : default width of the incoming count and of the duty value
//   PRD_W_DEF   : default width of the completed-period counter
//   DT_CNT_W    : width of the dead-time down-counter (DT range 1..15)
package pwm_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int PRD_W_DEF = 16;
    localparam int DT_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } pwm_state_t;

endpackage

// File: rtl/pwm_dt.sv
// pwm_dt: dead-time inserter for the complementary PWM pair.
// Every edge of i_raw forces both outputs low for DT clocks before the new
// side is driven; an edge inside the gap restarts the gap. Outputs are
// registered and can never be high together.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   i_raw    in   gated compare result (high side request)
//   i_act    in   controller is in ARM or RUN (low side allowed)
//   o_pwm_h  out  high-side drive
//   o_pwm_l  out  low-side drive
module pwm_dt
    import pwm_pkg::*;
#(
    parameter int DT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    input  logic i_act,
    output logic o_pwm_h,
    output logic o_pwm_l
);

    // The edge cycle itself is the first low cycle, so the counter loads DT-1.
    localparam logic [DT_CNT_W-1:0] DT_LOAD = DT_CNT_W'(DT - 1);

    logic                r_raw;
    logic [DT_CNT_W-1:0] r_cnt;
    logic                r_pwm_h;
    logic                r_pwm_l;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_raw   <= 1'b0;
            r_cnt   <= '0;
            r_pwm_h <= 1'b0;
            r_pwm_l <= 1'b0;
        end else begin
            r_raw <= i_raw;
            if (i_raw != r_raw) begin
                r_cnt   <= DT_LOAD;
                r_pwm_h <= 1'b0;
                r_pwm_l <= 1'b0;
            end else if (r_cnt != '0) begin
                r_cnt   <= r_cnt - 1'b1;
                r_pwm_h <= 1'b0;
                r_pwm_l <= 1'b0;
            end else begin
                r_pwm_h <= i_raw;
                r_pwm_l <= i_act && !i_raw;
            end
        end
    end

    assign o_pwm_h = r_pwm_h;
    assign o_pwm_l = r_pwm_l;

endmodule

// File: rtl/pwm_cmp.sv
// pwm_cmp: compares the upstream free-running count with a duty value and
// drives a registered complementary PWM pair, a per-period strobe and a
// wrapping completed-period counter. Duty arrives over a valid/ready
// handshake into a shadow register that is only applied at a period
// boundary (cnt_i == 0), so a period is never cut short or stretched.
//
// Build option: define PWM_DEADTIME_EN to insert DT clocks of both-low dead
// time on every compare edge (pwm_dt). Without it pwm_l is the complement of
// pwm_h while armed or running and DT is unused apart from its range check.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   cnt_i       in   [CNT_W] count from upstream counter
//   en          in   run request, sampled at period boundaries while running
//   duty        in   [CNT_W] requested duty
//   duty_vld    in   duty valid
//   duty_rdy    out  shadow register free
//   pwm_h       out  high-side PWM
//   pwm_l       out  low-side PWM
//   period_stb  out  one-cycle pulse per completed period
//   prd_cnt     out  [PRD_W] completed periods, wraps
//
// state | meaning
// IDLE  | outputs low, waiting for en
// ARM   | enabled, waiting for the first boundary to start a clean period
// RUN   | comparing phase against the active duty
module pwm_cmp
    import pwm_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter bit INC_DEC = 1'b1,
    parameter int DT      = 4,
    parameter int PRD_W   = PRD_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             en,
    input  logic [CNT_W-1:0] duty,
    input  logic             duty_vld,
    output logic             duty_rdy,
    output logic             pwm_h,
    output logic             pwm_l,
    output logic             period_stb,
    output logic [PRD_W-1:0] prd_cnt
);

    if (DT < 1 || DT > 15) begin : g_dt_range
        $error("pwm_cmp: DT must be in 1..15");
    end

    pwm_state_t       r_state;
    pwm_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_active;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pending;
    logic             r_stb;
    logic [PRD_W-1:0] r_prd;

    logic [CNT_W-1:0] w_phase;
    logic [CNT_W-1:0] w_active_nxt;
    logic             w_bnd;
    logic             w_hs;
    logic             w_apply;
    logic             w_stb_nxt;
    logic             w_raw;
    logic             w_act;

    // A down-counting source runs 0,255,254,...; negating it gives the same
    // 0..255 ramp as an up-counter, so one comparator serves both builds.
    assign w_phase  = INC_DEC ? cnt_i : ({CNT_W{1'b0}} - cnt_i);
    assign w_bnd    = (cnt_i == '0);
    assign w_hs     = duty_vld && !r_pending;
    assign duty_rdy = !r_pending;

    always_comb begin
        w_state_nxt = r_state;
        w_apply     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                if (w_bnd) begin
                    w_apply     = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_bnd) begin
                    w_apply = 1'b1;
                    if (!en) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The boundary cycle is phase 0 of the new period, so it already compares
    // against the duty being applied on that same edge.
    assign w_active_nxt = (w_apply && r_pending) ? r_shadow : r_active;
    assign w_stb_nxt    = (r_state == ST_RUN) && w_bnd;
    assign w_raw        = (w_state_nxt == ST_RUN) && (w_phase < w_active_nxt);
    assign w_act        = (w_state_nxt != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_active  <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_stb     <= 1'b0;
            r_prd     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= w_active_nxt;
            // A write landing on a boundary is held for the next one.
            if (w_hs) begin
                r_shadow  <= duty;
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
            r_stb <= w_stb_nxt;
            if (w_stb_nxt) begin
                r_prd <= r_prd + 1'b1;
            end
        end
    end

    assign period_stb = r_stb;
    assign prd_cnt    = r_prd;

`ifdef PWM_DEADTIME_EN
    pwm_dt #(
        .DT(DT)
    ) u_pwm_dt (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (w_raw),
        .i_act  (w_act),
        .o_pwm_h(pwm_h),
        .o_pwm_l(pwm_l)
    );
`else
    logic r_pwm_h;
    logic r_pwm_l;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_h <= 1'b0;
            r_pwm_l <= 1'b0;
        end else begin
            r_pwm_h <= w_raw;
            r_pwm_l <= w_act && !w_raw;
        end
    end

    assign pwm_h = r_pwm_h;
    assign pwm_l = r_pwm_l;
`endif

endmodule
